// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder/subtractor controller:
// FSM state encodings and the counter width rule.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int WIDTH_MAX = 32;

    // Down-counter width for WIDTH bit positions; a 1-bit counter still exists at WIDTH=1.
    function automatic int cnt_w(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder cell used as the serial datapath slice.
// Purely combinational: zero latency, no flow control.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract over WIDTH cycles through one full_adder; done pulses WIDTH+1 cycles after start.
// start is only accepted in IDLE; requests during RUN/DONE are dropped, not queued.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_t             state_q;
    logic [WIDTH-1:0]   sh_a_q;
    logic [WIDTH-1:0]   sh_b_q;
    logic [WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]   res_d;
    logic [WIDTH-1:0]   sum_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic               busy_q;
    logic               done_q;
    logic               c_out_q;
    logic               fa_s;
    logic               fa_co;

    full_adder u_fa (
        .a_i  (sh_a_q[0]),
        .b_i  (sh_b_q[0]),
        .c_i  (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    always_comb begin
        res_d = (res_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            c_out_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        // Subtract is a + ~b + 1, so the inversion and the +1 are folded in here.
                        sh_a_q  <= a;
                        sh_b_q  <= b ^ {WIDTH{sub}};
                        carry_q <= sub ? 1'b1 : c_in;
                        cnt_q   <= CNT_W'(WIDTH - 1);
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sh_a_q  <= sh_a_q >> 1;
                    sh_b_q  <= sh_b_q >> 1;
                    res_q   <= res_d;
                    carry_q <= fa_co;
                    if (cnt_q == '0) begin
                        sum_q   <= res_d;
                        c_out_q <= fa_co;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign c_out = c_out_q;

endmodule
